// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, drives instruction memory and
// fills the IF/ID register; halts when the PC leaves the valid memory range.
module fetch_stage #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        halted
);

  localparam logic [0:0]  ST_RUN  = 1'b0;
  localparam logic [0:0]  ST_HALT = 1'b1;
  localparam logic [63:0] LAST_PC = 64'(MEM_SIZE) - 64'd4;

  logic [0:0]  r_state;
  logic [63:0] r_pc;
  logic [63:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;

  logic [0:0]  w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic [63:0] w_ifid_pc_nxt;
  logic [31:0] w_ifid_instr_nxt;
  logic        w_ifid_valid_nxt;
  logic        w_pc_ok;
  logic        w_fetch;

  assign w_pc_ok = (r_pc[1:0] == 2'b00) && (r_pc <= LAST_PC);
  assign w_fetch = (r_state == ST_RUN) && w_pc_ok;

  // Next-state for FSM, PC and IF/ID; branch beats stall, flush beats stall.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ifid_pc_nxt    = 64'd0;
    w_ifid_instr_nxt = 32'd0;
    w_ifid_valid_nxt = 1'b0;

    if (br_taken) begin
      w_state_nxt = ST_RUN;
      w_pc_nxt    = br_target;
    end else if (!stall) begin
      if (w_fetch) begin
        w_pc_nxt = r_pc + 64'd4;
      end else begin
        w_state_nxt = ST_HALT;
      end
    end

    if (flush) begin
      w_ifid_valid_nxt = 1'b0;
    end else if (stall) begin
      w_ifid_pc_nxt    = r_ifid_pc;
      w_ifid_instr_nxt = r_ifid_instr;
      w_ifid_valid_nxt = r_ifid_valid;
    end else if (w_fetch) begin
      w_ifid_pc_nxt    = r_pc;
      w_ifid_instr_nxt = imem_instr;
      w_ifid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_ifid_pc    <= 64'd0;
      r_ifid_instr <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
    end
  end

  assign imem_addr  = r_pc;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_valid = r_ifid_valid;
  assign halted     = (r_state == ST_HALT);

endmodule
